// File: rtl/opb_s2p_pkg.sv
// Shared constants for the OPB Simulink-to-PPC register: register offsets,
// STATUS field positions, miss-counter ceiling and the bus-slave state enum.
package opb_s2p_pkg;

    localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFF_TSTAMP = 32'h0000_0008;

    localparam int STAT_NEW_BIT  = 0;
    localparam int STAT_MISS_LSB = 8;
    localparam int STAT_MISS_W   = 8;

    localparam logic [7:0] MISS_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic [31:0] status_word(input logic new_flag, input logic [7:0] miss_cnt);
        logic [31:0] w;
        w = '0;
        w[STAT_NEW_BIT] = new_flag;
        w[STAT_MISS_LSB +: STAT_MISS_W] = miss_cnt;
        return w;
    endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_if.sv
// OPB slave-side signal bundle; bit 0 is the MSB, matching the OPB convention.
// master drives the request, slave returns data and handshake.
interface opb_register_simulink2ppc_if;

    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;

    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

endinterface

// File: rtl/opb_slave_ack.sv
// Address-window decode and IDLE/ACK/HOLD handshake FSM for a single-beat OPB slave.
// ack one cycle after a hit; next transfer only after select drops (HOLD->IDLE).
module opb_slave_ack
    import opb_s2p_pkg::*;
#(
    parameter int            AW   = 32,
    parameter logic [AW-1:0] BASE = '0,
    parameter logic [AW-1:0] HIGH = '1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          select_i,
    input  logic [AW-1:0] abus_i,
    output logic          ack_o,
    output logic          take_o,
    output logic [AW-1:0] off_o,
    output logic [AW-1:0] cap_off_o
);

    state_e        state_q, state_d;
    logic [AW-1:0] cap_off_q;
    logic          hit;

    assign hit    = select_i && (abus_i >= BASE) && (abus_i <= HIGH);
    assign off_o  = abus_i - BASE;
    assign take_o = (state_q == ST_IDLE) && hit;
    assign ack_o  = (state_q == ST_ACK);
    assign cap_off_o = cap_off_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cap_off_q <= '0;
        end else begin
            state_q <= state_d;
            if (take_o) begin
                cap_off_q <= off_o;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hit) state_d = ST_ACK;
            ST_ACK:  state_d = ST_HOLD;
            ST_HOLD: if (!select_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Fabric-to-PPC status register on OPB: DATA, STATUS (new/miss) and optional TSTAMP.
// Read data is a snapshot taken one cycle before xferAck; writes are acked and dropped.
// Optional cycle-stamp capture at offset 0x8 enabled by SIMULINK2PPC_TIMESTAMP_EN.
module opb_register_simulink2ppc
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100E300,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100E3FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                         OPB_Clk,
    input  logic                         OPB_Rst_n,
    opb_register_simulink2ppc_if.slave   opb,
    input  logic [31:0]                  user_data_in,
    input  logic                         user_valid
);

    localparam string unused_family = C_FAMILY;
    localparam int    unused_dwidth = C_OPB_DWIDTH;

    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Assert asynchronously, release only on an OPB_Clk edge.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    logic                    ack;
    logic                    take;
    logic [C_OPB_AWIDTH-1:0] off;
    logic [C_OPB_AWIDTH-1:0] cap_off;

    opb_slave_ack #(
        .AW   (C_OPB_AWIDTH),
        .BASE (C_BASEADDR),
        .HIGH (C_HIGHADDR)
    ) u_ack (
        .clk_i     (OPB_Clk),
        .rst_n_i   (rst_n),
        .select_i  (opb.OPB_select),
        .abus_i    (opb.OPB_ABus),
        .ack_o     (ack),
        .take_o    (take),
        .off_o     (off),
        .cap_off_o (cap_off)
    );

    logic [31:0] data_q;
    logic        new_q;
    logic [7:0]  miss_q;
    logic [31:0] snap_q;
    logic [31:0] rd_word;
    logic        clr;

`ifdef SIMULINK2PPC_TIMESTAMP_EN
    logic [31:0] ts_cnt_q;
    logic [31:0] ts_q;

    always_ff @(posedge OPB_Clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            if (user_valid) begin
                ts_q <= ts_cnt_q;
            end
        end
    end
`endif

    always_comb begin
        rd_word = '0;
        case (off)
            OFF_DATA:   rd_word = data_q;
            OFF_STATUS: rd_word = status_word(new_q, miss_q);
`ifdef SIMULINK2PPC_TIMESTAMP_EN
            OFF_TSTAMP: rd_word = ts_q;
`endif
            default:    rd_word = '0;
        endcase
    end

    assign clr = ack && opb.OPB_RNW && (cap_off == OFF_DATA);

    // A fresh update racing a clearing read keeps the flag but restarts the miss count.
    always_ff @(posedge OPB_Clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            new_q  <= 1'b0;
            miss_q <= '0;
            snap_q <= '0;
        end else begin
            if (take) begin
                snap_q <= rd_word;
            end
            if (user_valid) begin
                data_q <= user_data_in;
                new_q  <= 1'b1;
                if (clr) begin
                    miss_q <= '0;
                end else if (new_q && (miss_q != MISS_MAX)) begin
                    miss_q <= miss_q + 8'd1;
                end
            end else if (clr) begin
                new_q  <= 1'b0;
                miss_q <= '0;
            end
        end
    end

    assign opb.Sl_DBus    = (ack && opb.OPB_RNW) ? snap_q : '0;
    assign opb.Sl_xferAck = ack;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{opb.OPB_BE, opb.OPB_DBus, opb.OPB_seqAddr};

endmodule

// File: doc/opb_register_simulink2ppc.md
OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h0100E300, first byte address of the register window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h0100E3FF, last byte address of the register window.
REQ-003 SHALL have parameter C_OPB_AWIDTH, default 32, OPB address width.
REQ-004 SHALL have parameter C_OPB_DWIDTH, default 32, OPB data width.
REQ-005 SHALL have parameter C_FAMILY, default "virtex6", target family (informational).
REQ-006 SHALL have port OPB_Clk, in, 1, the single clock for all logic.
REQ-007 SHALL have port OPB_Rst_n, in, 1, reset; asynchronous, active-low.
REQ-008 SHALL have OPB inputs: OPB_ABus in [0:31]; OPB_BE in [0:3]; OPB_DBus in [0:31]; OPB_RNW in 1; OPB_select in 1; OPB_seqAddr in 1.
REQ-009 SHALL have OPB outputs: Sl_DBus out [0:31]; Sl_xferAck out 1; Sl_errAck out 1; Sl_retry out 1; Sl_toutSup out 1.
REQ-010 SHALL have user inputs: user_data_in in [31:0], value from fabric; user_valid in 1, single-cycle update strobe.

Function
REQ-011 Hit SHALL be: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; register offset = OPB_ABus - C_BASEADDR.
REQ-012 FSM SHALL use states IDLE, ACK, HOLD: IDLE->ACK on hit; ACK->HOLD unconditionally; HOLD->IDLE when OPB_select=0; IDLE->IDLE otherwise.
REQ-013 Sl_xferAck SHALL be 1 only in ACK: exactly one cycle, and one cycle after the hit is sampled.
REQ-014 Sl_DBus SHALL carry the read word only in ACK when OPB_RNW=1, and SHALL be 0 at all other times (OR-bus).
REQ-015 The read word SHALL be registered on the IDLE->ACK edge from the decoded offset, giving a coherent snapshot.
REQ-016 Offset 0x0 (DATA) SHALL return data_reg.
REQ-017 Offset 0x4 (STATUS) SHALL return: bit0 = new_flag; bits 15:8 = miss_cnt; all other bits 0.
REQ-018 Offset 0x8 SHALL follow REQ-031 or REQ-032; every other offset SHALL read 0.
REQ-019 Writes (OPB_RNW=0) SHALL be acknowledged per REQ-013 and SHALL have no effect; OPB_BE and OPB_seqAddr SHALL be ignored.
REQ-020 Sl_errAck, Sl_retry and Sl_toutSup SHALL be constant 0.
REQ-021 On user_valid=1: data_reg SHALL take user_data_in at that edge and new_flag SHALL be set.
REQ-022 If new_flag is already 1 when user_valid=1, miss_cnt SHALL increment by 1 and saturate at 255.
REQ-023 An ACK-state read of offset 0x0 SHALL clear new_flag and miss_cnt.
REQ-024 If user_valid coincides with a clearing read: the snapshot SHALL return the old data; new_flag SHALL end at 1; miss_cnt SHALL end at 0.
REQ-025 Back-to-back transfers SHALL require OPB_select to deassert (HOLD->IDLE) before the next ACK.

Reset
REQ-026 While OPB_Rst_n=0: state=IDLE and data_reg, new_flag, miss_cnt, snapshot, timestamp=0.
REQ-027 While OPB_Rst_n=0: all Sl_* outputs SHALL be 0.
REQ-028 Reset asserted mid-transfer SHALL abort it with no xferAck; after release, the FSM SHALL start in IDLE.
REQ-029 Reset release SHALL be synchronised so the design leaves reset on an OPB_Clk edge.

Configuration
REQ-030 Macro SIMULINK2PPC_TIMESTAMP_EN SHALL select the timestamp feature.
REQ-031 With SIMULINK2PPC_TIMESTAMP_EN defined: a free-running 32-bit cycle counter (wraps 0xFFFFFFFF->0) SHALL be captured into ts_reg on each user_valid, and offset 0x8 SHALL return ts_reg.
REQ-032 Without SIMULINK2PPC_TIMESTAMP_EN: no counter or ts_reg SHALL exist, and offset 0x8 SHALL read 0.

Structure
REQ-033 Package opb_s2p_pkg SHALL hold the offset constants (DATA 0x0, STATUS 0x4, TSTAMP 0x8), the STATUS bit positions, MISS_MAX=255 and the FSM state enum.
REQ-034 Sub-module opb_slave_ack SHALL contain the hit decode and the IDLE/ACK/HOLD FSM, and SHALL output ack and the captured offset.

Verification
REQ-035 user_valid with 0xDEADBEEF; read 0x0 -> xferAck one cycle after select, Sl_DBus=0xDEADBEEF; then STATUS read -> 0x00000000.
REQ-036 Three user_valid pulses, no reads; STATUS read -> 0x00000201 (new=1, miss=2).
REQ-037 300 user_valid pulses with no reads; STATUS -> miss_cnt=0xFF.
REQ-038 user_valid with 0x2 in the same cycle as the ACK of a DATA read, prior data 0x1; read returns 0x1; STATUS then reads 0x00000001.
REQ-039 Write 0x12345678 to 0x0 -> ack asserted; DATA unchanged. Read 0x20 -> 0. Sl_DBus=0 outside ACK throughout.
REQ-040 Assert OPB_Rst_n=0 during ACK -> xferAck drops immediately and all registers read 0 after release. With the macro defined, the 0x8 value increases between two updates.
